aes_mode_engine: RTL and testbench

- Streaming block-cipher mode controller around one `aes_core` instance (`clk`/`rst`/`enc`/`aes_len`/`key`/`plaintext` → `ciphertext`/`valid`).
- Adds ECB, CBC and CTR modes with a configurable counter width.
- Uses valid/ready streaming for input and output blocks, a `last` flag per block, and chaining state that persists across the blocks of one message.
- Sits between the AXI register/DMA front end and `aes_core`.

---
 rtl/aes_mode_engine.sv | 255 +++++++++++++++++++++++++
 tb/tb_aes_mode_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mode_engine.sv
// rtl/aes_mode_engine.sv - ECB/CBC/CTR streaming mode controller around an iterative AES core

// Iterative AES-128/192/256: expands the key one word per cycle after reset, then one round per cycle.
module aes_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         enc,
  input  logic [1:0]   aes_len,
  input  logic [255:0] key,
  input  logic [127:0] plaintext,
  output logic [127:0] ciphertext,
  output logic         valid
);
  typedef enum logic [2:0] {K_LOAD, K_EXP, K_INIT, K_RND, K_DONE} kstate_t;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Field inverse as a^254 by square-and-multiply; 0 maps to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
    return gmul(r, r);
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = ginv(b);
    return v ^ rol(v, 1) ^ rol(v, 2) ^ rol(v, 3) ^ rol(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] b);
    return ginv(rol(b, 1) ^ rol(b, 3) ^ rol(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // SubBytes+ShiftRows (or their inverses); byte i sits at row i%4, column i/4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s, input logic inv);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!inv) t[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
        else      t[127-8*(4*c+r) -: 8] = isbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return t;
  endfunction

  // Circulant column mix: row r uses coefficient k[(j-r)%4] for input byte j.
  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [127:0] t;
    logic [31:0]  k;
    logic [7:0]   b;
    t = '0;
    k = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++)
          b = b ^ gmul(s[127-8*(4*c+j) -: 8], k[31-8*((j-r+4)%4) -: 8]);
        t[127-8*(4*c+r) -: 8] = b;
      end
    return t;
  endfunction

  kstate_t      kst;
  logic [31:0]  w [0:59];
  logic [5:0]   widx, last_w;
  logic [2:0]   kpos;
  logic [7:0]   rcon;
  logic [3:0]   nk, nr, rnd, rk_idx;
  logic [31:0]  wprev, tw, wnew;
  logic [127:0] rk, st, rnd_out;

  // Key-size decode, next schedule word, and the current round key and round result.
  always_comb begin
    case (aes_len)
      2'b10:   nk = 4'd6;
      2'b11:   nk = 4'd8;
      default: nk = 4'd4;
    endcase
    nr     = nk + 4'd6;
    last_w = {nr, 2'b00} + 6'd3;
    wprev  = w[widx - 6'd1];
    tw     = wprev;
    if (kpos == 3'd0)                    tw = subw({wprev[23:0], wprev[31:24]}) ^ {rcon, 24'h0};
    else if (nk == 4'd8 && kpos == 3'd4) tw = subw(wprev);
    wnew   = w[widx - {2'b00, nk}] ^ tw;
    rk_idx = (kst == K_INIT) ? (enc ? 4'd0 : nr) : rnd;
    rk     = {w[{rk_idx, 2'b00}], w[{rk_idx, 2'b01}], w[{rk_idx, 2'b10}], w[{rk_idx, 2'b11}]};
    if (enc) rnd_out = ((rnd == nr) ? sub_shift(st, 1'b0) : mix(sub_shift(st, 1'b0), 1'b0)) ^ rk;
    else     rnd_out = (rnd == 4'd0) ? (sub_shift(st, 1'b1) ^ rk) : mix(sub_shift(st, 1'b1) ^ rk, 1'b1);
  end

  // Key expansion, then rounds; result held with valid until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      kst <= K_LOAD; valid <= 1'b0; st <= '0;
      widx <= '0; kpos <= '0; rcon <= '0; rnd <= '0;
    end else begin
      case (kst)
        K_LOAD: begin
          for (int i = 0; i < 8; i++) w[i] <= key[255-32*i -: 32];
          widx <= {2'b00, nk}; kpos <= 3'd0; rcon <= 8'h01; kst <= K_EXP;
        end
        K_EXP: begin
          w[widx] <= wnew;
          widx    <= widx + 6'd1;
          kpos    <= ({1'b0, kpos} == nk - 4'd1) ? 3'd0 : kpos + 3'd1;
          if (kpos == 3'd0) rcon <= xt(rcon);
          if (widx == last_w) kst <= K_INIT;
        end
        K_INIT: begin
          st  <= plaintext ^ rk;
          rnd <= enc ? 4'd1 : nr - 4'd1;
          kst <= K_RND;
        end
        K_RND: begin
          st  <= rnd_out;
          rnd <= enc ? rnd + 4'd1 : rnd - 4'd1;
          if ((enc && rnd == nr) || (!enc && rnd == 4'd0)) begin
            kst <= K_DONE; valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ciphertext = st;
endmodule

// Mode controller: one block in flight, chaining state updated at each output handshake.
module aes_mode_engine #(
  parameter int CTR_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 enc,
  input  logic [1:0]           aes_len,
  input  logic [255:0]         key,
  input  logic [127:0]         iv,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] block_cnt
);
  typedef enum logic [2:0] {IDLE, WAIT_IN, LOAD, RUN, OUT, FIN} state_t;
  localparam logic [1:0]   M_CBC    = 2'b01;
  localparam logic [1:0]   M_CTR    = 2'b10;
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_WIDTH);

  state_t       state;
  logic [1:0]   cfg_mode, cfg_len;
  logic         cfg_enc, core_enc, last_reg, core_valid;
  logic [255:0] cfg_key;
  logic [127:0] chain, x_reg, core_in, core_out;

  aes_core u_core (
    .clk       (clk),
    .rst       (rst | (state == LOAD)),
    .enc       (core_enc),
    .aes_len   (cfg_len),
    .key       (cfg_key),
    .plaintext (core_in),
    .ciphertext(core_out),
    .valid     (core_valid)
  );

  // Message FSM with registered handshake/status outputs and chaining state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE; cfg_mode <= '0; cfg_len <= '0; cfg_enc <= 1'b0; cfg_key <= '0;
      chain <= '0; x_reg <= '0; core_in <= '0; core_enc <= 1'b0; last_reg <= 1'b0;
      in_ready <= 1'b0; out_valid <= 1'b0; out_data <= '0; out_last <= 1'b0;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0; block_cnt <= '0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (mode == 2'b11 || aes_len == 2'b00) err <= 1'b1;
          else begin
            cfg_mode <= mode; cfg_enc <= enc; cfg_len <= aes_len; cfg_key <= key;
            chain <= iv; block_cnt <= '0; busy <= 1'b1; in_ready <= 1'b1; state <= WAIT_IN;
          end
        end
        WAIT_IN: if (in_valid) begin
          x_reg    <= in_data;
          last_reg <= in_last;
          core_enc <= (cfg_mode == M_CTR) ? 1'b1 : cfg_enc;
          if (cfg_mode == M_CTR)                core_in <= chain;
          else if (cfg_mode == M_CBC && cfg_enc) core_in <= in_data ^ chain;
          else                                   core_in <= in_data;
          in_ready <= 1'b0;
          state    <= LOAD;
        end
        LOAD: state <= RUN;
        RUN: if (core_valid) begin
          if (cfg_mode == M_CTR)                  out_data <= x_reg ^ core_out;
          else if (cfg_mode == M_CBC && !cfg_enc) out_data <= core_out ^ chain;
          else                                    out_data <= core_out;
          out_last  <= last_reg;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          block_cnt <= block_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          if (cfg_mode == M_CTR)      chain <= (chain & ~CTR_MASK) | ((chain + 128'd1) & CTR_MASK);
          else if (cfg_mode == M_CBC) chain <= cfg_enc ? out_data : x_reg;
          if (out_last) begin
            done <= 1'b1; busy <= 1'b0; state <= FIN;
          end else begin
            in_ready <= 1'b1; state <= WAIT_IN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_mode_engine.sv
// tb/tb_aes_mode_engine.sv - directed and randomized checks of aes_mode_engine against a block-level AES/mode model

module tb_aes_mode_engine;
  logic         clk = 1'b0;
  logic         rst, start, enc, in_valid, in_last, out_ready;
  logic [1:0]   mode, aes_len;
  logic [255:0] key;
  logic [127:0] iv, in_data;
  logic         in_ready, out_valid, out_last, busy, done, err;
  logic [127:0] out_data;
  logic [15:0]  block_cnt;

  int n_asrt = 0;
  int n_fail = 0;
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  aes_mode_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .enc(enc), .aes_len(aes_len),
    .key(key), .iv(iv), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .err(err), .block_cnt(block_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // Whole-block AES reference using table S-boxes and textbook round order.
  function automatic logic [127:0] m_aes(input logic [127:0] blk, input logic [255:0] k,
                                         input logic [1:0] len, input bit e);
    int nk, nr;
    logic [31:0] w [60];
    logic [31:0] tmp, wd;
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    nk = (len == 2'b01) ? 4 : (len == 2'b10) ? 6 : 8;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % 8 == 4)
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
    for (int r0 = 0; r0 <= nr; r0++) begin
      int r;
      r = e ? r0 : nr - r0;
      if (e && r0 > 0) begin
        for (int c = 0; c < 4; c++) for (int q = 0; q < 4; q++) t[4*c+q] = sb[s[4*((c+q)%4)+q]];
        s = t;
        if (r0 < nr) for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      if (!e && r0 > 0) begin
        for (int c = 0; c < 4; c++) for (int q = 0; q < 4; q++) t[4*c+q] = isb[s[4*((c-q+4)%4)+q]];
        s = t;
      end
      for (int i = 0; i < 16; i++) begin
        wd = w[4*r + i/4];
        s[i] ^= wd[31-8*(i%4) -: 8];
      end
      if (!e && r0 > 0 && r0 < nr) for (int c = 0; c < 4; c++) begin
        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
        s[4*c]   = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
        s[4*c+1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
        s[4*c+2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
        s[4*c+3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic e, input logic [1:0] l,
                          input logic [255:0] k, input logic [127:0] v);
    @(negedge clk);
    mode = m; enc = e; aes_len = l; key = k; iv = v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Push one block, wait for its result, hold back-pressure for 'hold' cycles, then accept it.
  task automatic xfer(input logic [127:0] d, input logic l, input int hold,
                      output logic [127:0] od, output logic ol, output bit ok, output bit stable);
    int k;
    in_data = d; in_last = l; in_valid = 1'b1; out_ready = 1'b0; k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0; k = 0;
    while (!out_valid && k < 500) begin @(negedge clk); k++; end
    ok = ok && out_valid;
    od = out_data; ol = out_last; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out_data !== od || out_last !== ol || !out_valid || in_ready) stable = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  localparam logic [255:0] K1   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] IV1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IVC  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

  initial begin
    logic [7:0] p, q;
    logic [127:0] od, x1, x2, ivw, c, x, ex, kr;
    logic [255:0] rk;
    logic ol;
    bit ok, stb, saw_done, saw_ov;
    int md, nb;
    logic e;
    logic [1:0] ln;

    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0}; q = q ^ {q[5:0], 2'b0}; q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = i[7:0];

    rst = 1'b1; start = 0; mode = 0; enc = 0; aes_len = 0; key = 0; iv = 0;
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {in_ready, out_valid, out_last, busy, done, err}, 0);
    chk("reset_data", out_data, 0);
    chk("reset_cnt", block_cnt, 0);
    rst = 1'b0;

    do_start(2'b00, 1'b1, 2'b01, K1, 0);
    chk("ecb_busy", busy, 1);
    xfer(P1, 1'b1, 0, od, ol, ok, stb);
    chk("ecb_ok", ok, 1);
    chk("ecb_enc128", od, 128'h3ad77bb40d7a3660a89ecaf32466ef97);
    chk("ecb_last", ol, 1);
    chk("ecb_done", {done, busy}, 2'b10);
    chk("ecb_cnt", block_cnt, 1);
    @(negedge clk);
    chk("ecb_done_pulse", done, 0);
    chk("ecb_cnt_held", block_cnt, 1);

    do_start(2'b00, 1'b0, 2'b11, K256, 0);
    xfer(128'h8ea2b7ca516745bfeafc49904b496089, 1'b1, 0, od, ol, ok, stb);
    chk("ecb_dec256", od, 128'h00112233445566778899aabbccddeeff);

    do_start(2'b01, 1'b1, 2'b01, K1, IV1);
    xfer(P1, 1'b0, 10, od, ol, ok, stb);
    chk("cbc_enc_b1", od, 128'h7649abac8119b246cee98e9b12e9197d);
    chk("cbc_backpressure_stable", stb, 1);
    chk("cbc_b1_notlast", ol, 0);
    xfer(P2, 1'b1, 0, od, ol, ok, stb);
    chk("cbc_enc_b2", od, 128'h5086cb9b507219ee95db113a917678b2);
    chk("cbc_cnt", block_cnt, 2);
    do_start(2'b01, 1'b0, 2'b01, K1, IV1);
    xfer(128'h7649abac8119b246cee98e9b12e9197d, 1'b0, 0, od, ol, ok, stb);
    chk("cbc_dec_b1", od, P1);
    xfer(128'h5086cb9b507219ee95db113a917678b2, 1'b1, 0, od, ol, ok, stb);
    chk("cbc_dec_b2", od, P2);

    do_start(2'b10, 1'b0, 2'b01, K1, IVC);
    xfer(P1, 1'b0, 0, od, ol, ok, stb);
    chk("ctr_b1", od, 128'h874d6191b620e3261bef6864990db6ce);
    xfer(P2, 1'b1, 0, od, ol, ok, stb);
    chk("ctr_b2", od, 128'h9806f66b7970fdff8617187bb9fffdff);
    chk("ctr_b2_model", od, P2 ^ m_aes(128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00, K1, 2'b01, 1));

    ivw = {$urandom(), $urandom(), $urandom(), 32'hffffffff};
    x1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    x2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_start(2'b10, 1'b1, 2'b01, K1, ivw);
    xfer(x1, 1'b0, 0, od, ol, ok, stb);
    chk("ctr_wrap_b1", od, x1 ^ m_aes(ivw, K1, 2'b01, 1));
    xfer(x2, 1'b1, 0, od, ol, ok, stb);
    chk("ctr_wrap_b2", od, x2 ^ m_aes({ivw[127:32], 32'h0}, K1, 2'b01, 1));

    do_start(2'b11, 1'b1, 2'b01, K1, 0);
    chk("err_mode", {err, busy, in_ready}, 3'b100);
    @(negedge clk);
    chk("err_pulse", {err, busy}, 2'b00);
    do_start(2'b00, 1'b1, 2'b00, K1, 0);
    chk("err_len", {err, busy, in_ready}, 3'b100);

    do_start(2'b00, 1'b1, 2'b01, K1, 0);
    do_start(2'b10, 1'b0, 2'b11, K256, IVC);
    chk("start_busy_ignored", {busy, in_ready, err}, 3'b110);
    xfer(P1, 1'b1, 0, od, ol, ok, stb);
    chk("start_busy_result", od, 128'h3ad77bb40d7a3660a89ecaf32466ef97);

    do_start(2'b00, 1'b1, 2'b01, K1, 0);
    in_data = P1; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ctrl", {in_ready, out_valid, out_last, busy, done, err}, 0);
    chk("rst_mid_data", out_data, 0);
    chk("rst_mid_cnt", block_cnt, 0);
    rst = 1'b0;
    saw_done = 0; saw_ov = 0;
    repeat (100) begin
      @(negedge clk);
      saw_done |= done; saw_ov |= out_valid;
    end
    chk("rst_no_done", {saw_done, saw_ov}, 0);
    do_start(2'b00, 1'b1, 2'b01, K1, 0);
    xfer(P1, 1'b1, 0, od, ol, ok, stb);
    chk("rst_recover", od, 128'h3ad77bb40d7a3660a89ecaf32466ef97);

    for (int m = 0; m < 6; m++) begin
      md = $urandom_range(0, 2);
      e  = 1'($urandom_range(0, 1));
      ln = 2'($urandom_range(1, 3));
      rk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      c  = {$urandom(), $urandom(), $urandom(), $urandom()};
      nb = $urandom_range(1, 3);
      do_start(md[1:0], e, ln, rk, c);
      for (int b = 0; b < nb; b++) begin
        x = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (md == 0) ex = m_aes(x, rk, ln, e);
        else if (md == 1 && e) begin ex = m_aes(x ^ c, rk, ln, 1); c = ex; end
        else if (md == 1) begin ex = m_aes(x, rk, ln, 0) ^ c; c = x; end
        else begin
          kr = m_aes(c, rk, ln, 1); ex = x ^ kr;
          c[31:0] = c[31:0] + 32'd1;
        end
        xfer(x, b == nb - 1, $urandom_range(0, 3), od, ol, ok, stb);
        chk($sformatf("rnd%0d_b%0d_ok", m, b), {ok, stb}, 2'b11);
        chk($sformatf("rnd%0d_b%0d_data", m, b), od, ex);
        chk($sformatf("rnd%0d_b%0d_last", m, b), ol, (b == nb - 1) ? 1 : 0);
      end
      chk($sformatf("rnd%0d_done", m), done, 1);
      chk($sformatf("rnd%0d_cnt", m), block_cnt, nb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
